instruction_loader: RTL and testbench
=====================================

# instruction_loader

Sequential program loader that feeds the MIPS pipeline's instruction memory. It takes a byte stream from the debug UART receiver and packs it MSB-first into 32-bit instruction words. It writes each word to consecutive instruction-memory addresses and stops at the HALT word. It encodes and writes the same opcode space that the pipeline control decoder consumes, and can optionally reject words whose opcode the decoder does not support.

## Interface
- NB_DATA, 32, instruction word width
- NB_BYTE, 8, received byte width
- NB_ADDR, 10, instruction-memory word-address width
- NB_OPCODE, 6, opcode field width (word bits [31:26])
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse: clear and arm loader (accepted in any state)
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data
- o_imem_wr_en  out  1  instruction-memory write enable, one cycle per word
- o_imem_addr  out  NB_ADDR  word address for the write
- o_imem_data  out  NB_DATA  word being written
- o_busy  out  1  high in RECV/CHECK/WRITE
- o_done  out  1  sticky: HALT written
- o_error  out  1  sticky: bad opcode or memory overflow
- o_word_count  out  NB_ADDR+1  words written since last start

## Operation
- States: IDLE, RECV, CHECK, WRITE, DONE, ERROR.
- Reset (any state, mid-word included): state IDLE, all outputs 0, byte index 0, address 0, word register 0.
- IDLE, DONE, ERROR: i_rx_valid is ignored. i_start moves to RECV and clears the word register, byte index, address, count, o_done and o_error.
- RECV: each i_rx_valid shifts the byte in: word = {word[23:0], byte}. The byte index counts 0..3. The 4th byte moves to CHECK.
- CHECK (1 cycle):
  - HALT_WORD always passes.
  - Otherwise, with the opcode check enabled, an unsupported opcode moves to ERROR with no write.
  - Otherwise moves to WRITE.
- Supported opcodes: 0x00, 0x04, 0x05, 0x08, 0x0a, 0x0c, 0x0d, 0x0e, 0x0f, 0x20–0x25, 0x28, 0x29, 0x2b.
- WRITE (1 cycle): o_imem_wr_en=1, o_imem_addr=address, o_imem_data=word; count increments. Next state:
  - DONE if the word is HALT_WORD.
  - Else ERROR if address == 2^NB_ADDR−1 (memory full, no HALT).
  - Else address+1, byte index 0, back to RECV.
- i_start in RECV/CHECK/WRITE aborts the load with no write that cycle and restarts in RECV at address 0.
- i_rx_valid in CHECK/WRITE is dropped. Upstream guarantees ≥3 cycles between bytes.
- o_imem_addr and o_imem_data hold their last values outside WRITE. Only o_imem_wr_en qualifies them.

## Timing
- All outputs are registered.
- 4th byte sampled at edge N → CHECK in cycle N+1 → o_imem_wr_en high for exactly cycle N+2.
- o_word_count updates at the edge ending WRITE.
- o_done/o_error assert the cycle after the WRITE/CHECK that caused them and hold until i_start or reset.
- o_busy drops in the same cycle o_done/o_error rises.
- Address wraps never: overflow ends in ERROR, with the full memory written.

## Configuration
- LOADER_OPCODE_CHECK_EN defined: CHECK applies the supported-opcode list; a failing word sets o_error and is not written.
- Not defined: CHECK always passes. Every word is written and o_error arises only from memory overflow.

## Test plan
- Start; bytes 20 08 00 05, FF FF FF FF → writes addr0=0x20080005, addr1=0xFFFFFFFF; o_done=1, o_word_count=2, o_busy=0.
- Start; bytes FC 00 00 00 → with LOADER_OPCODE_CHECK_EN: no write, o_error=1, o_word_count=0. Without it: addr0=0xFC000000 written, loader returns to RECV.
- NB_ADDR=2; start; four words 0x8C010004 → four writes at addr0..3, then o_error=1, o_word_count=4, o_done=0.
- Start, bytes 20 08, then i_reset low for 1 cycle → all outputs 0, state IDLE. Further bytes cause no write until i_start.
- i_rx_valid with bytes in IDLE → no write, count 0. Start, 2 bytes, start again, then 8C 01 00 04 → single write addr0=0x8C010004.
- Byte timing: 4th byte at edge N → o_imem_wr_en high only in cycle N+2.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader: packs a UART byte stream MSB-first into 32-bit
// instruction words and writes them to consecutive instruction-memory
// addresses until the HALT word is written.
//
// Optional build macro: LOADER_OPCODE_CHECK_EN
//   defined     -> CHECK rejects words whose opcode the decoder does not support
//   not defined -> every received word is written
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for i_start; bytes ignored
// RECV  | shifting bytes into the word register
// CHECK | one cycle, word complete, deciding whether to write it
// WRITE | one cycle, write strobe high, address/count advance
// DONE  | HALT word written; waits for i_start
// ERROR | bad opcode or memory full; waits for i_start

module instruction_loader #(
    parameter int               NB_DATA   = 32,
    parameter int               NB_BYTE   = 8,
    parameter int               NB_ADDR   = 10,
    parameter int               NB_OPCODE = 6,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_imem_wr_en,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0] o_imem_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [NB_ADDR:0]   o_word_count
);

    localparam int                NB_IDX   = $clog2(NB_DATA / NB_BYTE);
    localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(NB_DATA / NB_BYTE - 1);
    localparam logic [NB_IDX-1:0] IDX_ONE  = NB_IDX'(1);
    localparam logic [NB_ADDR-1:0] ADDR_ONE = NB_ADDR'(1);
    localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;
    localparam logic [NB_ADDR:0]   CNT_ONE  = (NB_ADDR + 1)'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        CHECK = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t             state_q, state_n;
    logic [NB_DATA-1:0] word_q, word_n;
    logic [NB_IDX-1:0]  idx_q, idx_n;
    logic [NB_ADDR-1:0] addr_q, addr_n;
    logic [NB_ADDR:0]   count_q, count_n;
    logic               done_q, done_n;
    logic               error_q, error_n;
    logic               busy_q, busy_n;
    logic               wr_en_q, wr_en_n;
    logic [NB_ADDR-1:0] imem_addr_q, imem_addr_n;
    logic [NB_DATA-1:0] imem_data_q, imem_data_n;
    logic               word_ok;

`ifdef LOADER_OPCODE_CHECK_EN
    // Opcodes understood by the pipeline control decoder.
    function automatic logic opcode_supported(input logic [NB_OPCODE-1:0] op);
        case (op)
            6'h00, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2b: opcode_supported = 1'b1;
            default:             opcode_supported = 1'b0;
        endcase
    endfunction

    // HALT always passes even though its opcode field is not a real opcode.
    always_comb begin
        word_ok = (word_q == HALT_WORD) ||
                  opcode_supported(word_q[NB_DATA-1 -: NB_OPCODE]);
    end
`else
    // Without the opcode filter every complete word is written.
    always_comb begin
        word_ok = 1'b1;
    end
`endif

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_n     = state_q;
        word_n      = word_q;
        idx_n       = idx_q;
        addr_n      = addr_q;
        count_n     = count_q;
        done_n      = done_q;
        error_n     = error_q;
        wr_en_n     = 1'b0;
        imem_addr_n = imem_addr_q;
        imem_data_n = imem_data_q;

        if (i_start) begin
            // Start wins in every state, including mid-load. A start landing
            // in WRITE cannot retract the strobe registered at the end of
            // CHECK, but the count restarts from zero.
            state_n = RECV;
            word_n  = '0;
            idx_n   = '0;
            addr_n  = '0;
            count_n = '0;
            done_n  = 1'b0;
            error_n = 1'b0;
        end else begin
            case (state_q)
                RECV: begin
                    if (i_rx_valid) begin
                        word_n = {word_q[NB_DATA-NB_BYTE-1:0], i_rx_data};
                        if (idx_q == IDX_LAST) begin
                            idx_n   = '0;
                            state_n = CHECK;
                        end else begin
                            idx_n = idx_q + IDX_ONE;
                        end
                    end
                end
                CHECK: begin
                    if (word_ok) begin
                        state_n     = WRITE;
                        wr_en_n     = 1'b1;
                        imem_addr_n = addr_q;
                        imem_data_n = word_q;
                    end else begin
                        state_n = ERROR;
                        error_n = 1'b1;
                    end
                end
                WRITE: begin
                    count_n = count_q + CNT_ONE;
                    if (word_q == HALT_WORD) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (addr_q == ADDR_MAX) begin
                        // Memory full without a HALT: never wrap.
                        state_n = ERROR;
                        error_n = 1'b1;
                    end else begin
                        addr_n  = addr_q + ADDR_ONE;
                        idx_n   = '0;
                        state_n = RECV;
                    end
                end
                default: begin
                    // IDLE, DONE, ERROR: bytes are ignored until i_start.
                end
            endcase
        end

        busy_n = (state_n == RECV) || (state_n == CHECK) || (state_n == WRITE);
    end

    // State and registered outputs; reset clears everything.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
        end else begin
            state_q     <= state_n;
            word_q      <= word_n;
            idx_q       <= idx_n;
            addr_q      <= addr_n;
            count_q     <= count_n;
            done_q      <= done_n;
            error_q     <= error_n;
            busy_q      <= busy_n;
            wr_en_q     <= wr_en_n;
            imem_addr_q <= imem_addr_n;
            imem_data_q <= imem_data_n;
        end
    end

    assign o_imem_wr_en = wr_en_q;
    assign o_imem_addr  = imem_addr_q;
    assign o_imem_data  = imem_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_word_count = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a default-size instance and a
// four-word instance (NB_ADDR=2) share the same stimulus; writes from each
// are captured into queues and compared against hand-computed values.
module tb_instruction_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        wr_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        busy, done, error;
    logic [10:0] word_count;

    logic        s_wr_en;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_data;
    logic        s_busy, s_done, s_error;
    logic [2:0]  s_word_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [1:0]  s_addr_q[$];
    logic [31:0] s_data_q[$];

    int n_last;

    instruction_loader dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_imem_wr_en (wr_en),
        .o_imem_addr  (imem_addr),
        .o_imem_data  (imem_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_word_count (word_count)
    );

    instruction_loader #(.NB_ADDR(2)) dut_small (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_imem_wr_en (s_wr_en),
        .o_imem_addr  (s_imem_addr),
        .o_imem_data  (s_imem_data),
        .o_busy       (s_busy),
        .o_done       (s_done),
        .o_error      (s_error),
        .o_word_count (s_word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter used to time the write strobe.
    always @(posedge clock) cyc <= cyc + 1;

    // Capture every cycle with a write strobe, away from the active edge.
    always @(negedge clock) begin
        if (wr_en) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_data);
            wr_cyc_q.push_back(cyc);
        end
        if (s_wr_en) begin
            s_addr_q.push_back(s_imem_addr);
            s_data_q.push_back(s_imem_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        s_addr_q.delete();
        s_data_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // One byte strobe, then a three-cycle gap. n is the edge count at sampling.
    task automatic send_byte(input logic [7:0] b, output int n);
        @(posedge clock); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        n        = cyc;
        rx_valid = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic send_word(input logic [31:0] w, output int n);
        int nb;
        send_byte(w[31:24], nb);
        send_byte(w[23:16], nb);
        send_byte(w[15:8],  nb);
        send_byte(w[7:0],   nb);
        n = nb;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_addr",  imem_addr, 0);
        check("rst_data",  imem_data, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_error", error, 0);
        check("rst_count", word_count, 0);
        reset = 1'b1;

        // Bytes while IDLE are ignored.
        clear_log();
        send_word(32'h8C010004, n_last);
        repeat (3) @(posedge clock); #1;
        check("idle_nwr",   wr_addr_q.size(), 0);
        check("idle_count", word_count, 0);
        check("idle_busy",  busy, 0);

        // Normal program: one instruction then HALT.
        clear_log();
        pulse_start();
        #1;
        check("start_busy", busy, 1);
        send_word(32'h20080005, n_last);
        check("t1_nwr_first", wr_cyc_q.size(), 1);
        if (wr_cyc_q.size() >= 1)
            check("t1_wr_timing", wr_cyc_q[0], n_last + 1);
        send_word(32'hFFFFFFFF, n_last);
        repeat (3) @(posedge clock); #1;
        check("t1_nwr", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("t1_a0", wr_addr_q[0], 0);
            check("t1_d0", wr_data_q[0], 32'h20080005);
            check("t1_a1", wr_addr_q[1], 1);
            check("t1_d1", wr_data_q[1], 32'hFFFFFFFF);
        end
        check("t1_done",  done, 1);
        check("t1_error", error, 0);
        check("t1_busy",  busy, 0);
        check("t1_count", word_count, 2);

        // DONE ignores further bytes.
        send_word(32'h8C010004, n_last);
        repeat (3) @(posedge clock); #1;
        check("done_nwr",   wr_addr_q.size(), 2);
        check("done_count", word_count, 2);

        // Unsupported opcode 0x3F.
        clear_log();
        pulse_start();
        #1;
        check("t2_done_clr", done, 0);
        send_word(32'hFC000000, n_last);
        repeat (3) @(posedge clock); #1;
`ifdef LOADER_OPCODE_CHECK_EN
        check("t2_nwr",   wr_addr_q.size(), 0);
        check("t2_error", error, 1);
        check("t2_count", word_count, 0);
        check("t2_busy",  busy, 0);
`else
        check("t2_nwr", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("t2_a0", wr_addr_q[0], 0);
            check("t2_d0", wr_data_q[0], 32'hFC000000);
        end
        check("t2_error", error, 0);
        check("t2_count", word_count, 1);
        check("t2_busy",  busy, 1);
`endif

        // Overflow: the 4-word instance fills and errors.
        clear_log();
        pulse_start();
        #1;
        check("t3_error_clr", error, 0);
        for (int k = 0; k < 4; k++)
            send_word(32'h8C010004, n_last);
        repeat (3) @(posedge clock); #1;
        check("t3_s_nwr", s_addr_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < s_addr_q.size()) begin
                check($sformatf("t3_s_a%0d", k), s_addr_q[k], k);
                check($sformatf("t3_s_d%0d", k), s_data_q[k], 32'h8C010004);
            end
        end
        check("t3_s_error", s_error, 1);
        check("t3_s_done",  s_done, 0);
        check("t3_s_busy",  s_busy, 0);
        check("t3_s_count", s_word_count, 4);
        check("t3_count",   word_count, 4);
        check("t3_error",   error, 0);
        check("t3_addr_hold", imem_addr, 3);

        // Reset in the middle of a word.
        clear_log();
        pulse_start();
        send_byte(8'h20, n_last);
        send_byte(8'h08, n_last);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("t4_wr_en", wr_en, 0);
        check("t4_addr",  imem_addr, 0);
        check("t4_data",  imem_data, 0);
        check("t4_busy",  busy, 0);
        check("t4_count", word_count, 0);
        check("t4_s_error", s_error, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        send_word(32'h00050000, n_last);
        repeat (3) @(posedge clock); #1;
        check("t4_nwr",  wr_addr_q.size(), 0);
        check("t4_busy_after", busy, 0);

        // Restart mid-word discards the partial bytes.
        clear_log();
        pulse_start();
        send_byte(8'h11, n_last);
        send_byte(8'h22, n_last);
        pulse_start();
        send_word(32'h8C010004, n_last);
        repeat (3) @(posedge clock); #1;
        check("t5_nwr", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("t5_a0", wr_addr_q[0], 0);
            check("t5_d0", wr_data_q[0], 32'h8C010004);
            check("t5_timing", wr_cyc_q[0], n_last + 1);
        end
        check("t5_count", word_count, 1);
        check("t5_busy",  busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
